// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I ID stage: decode, load-use hazard detection, ID/EX register
// Optional macro DECODE_STATS_EN adds stall/flush event counters.
module decode_stage #(
  parameter int XLEN           = 32,
  parameter int NOP_ON_ILLEGAL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            ex_flush,
  output logic            stall_if,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_a_pc,
  output logic            ex_alu_b_imm,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic [2:0]      ex_funct3,
  output logic            ex_illegal,
  output logic [31:0]     stat_stalls,
  output logic [31:0]     stat_flushes
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [XLEN-1:0] w_imm;
  logic [3:0]      w_alu_arith, w_alu_op;
  logic            w_a_pc, w_b_imm, w_mem_read, w_mem_write, w_wr, w_m2r;
  logic            w_branch, w_jump, w_illegal, w_rs1_used, w_rs2_used;
  logic            w_reg_write, w_hazard, w_bubble;

  assign w_opcode = if_instr[6:0];
  assign w_funct3 = if_instr[14:12];
  assign w_rd     = if_instr[11:7];
  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];

  assign w_imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
  assign w_imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign w_imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
  assign w_imm_u = {if_instr[31:12], 12'b0};
  assign w_imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

  // instr[30] selects SUB only for register-register ops; shifts use it for both forms
  always_comb begin
    w_alu_arith = ALU_ADD;
    case (w_funct3)
      3'd0:    w_alu_arith = (w_opcode == OPC_OP && if_instr[30]) ? ALU_SUB : ALU_ADD;
      3'd1:    w_alu_arith = ALU_SLL;
      3'd2:    w_alu_arith = ALU_SLT;
      3'd3:    w_alu_arith = ALU_SLTU;
      3'd4:    w_alu_arith = ALU_XOR;
      3'd5:    w_alu_arith = if_instr[30] ? ALU_SRA : ALU_SRL;
      3'd6:    w_alu_arith = ALU_OR;
      default: w_alu_arith = ALU_AND;
    endcase
  end

  always_comb begin
    w_imm       = '0;
    w_alu_op    = ALU_ADD;
    w_a_pc      = 1'b0;
    w_b_imm     = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_wr        = 1'b0;
    w_m2r       = 1'b0;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
    w_illegal   = 1'b0;
    w_rs1_used  = 1'b0;
    w_rs2_used  = 1'b0;
    case (w_opcode)
      OPC_LUI:    begin w_imm = w_imm_u; w_alu_op = ALU_PASSB; w_b_imm = 1'b1; w_wr = 1'b1; end
      OPC_AUIPC:  begin w_imm = w_imm_u; w_a_pc = 1'b1; w_b_imm = 1'b1; w_wr = 1'b1; end
      OPC_JAL:    begin w_imm = w_imm_j; w_a_pc = 1'b1; w_b_imm = 1'b1; w_wr = 1'b1; w_jump = 1'b1; end
      OPC_JALR: begin
        w_imm = w_imm_i; w_a_pc = 1'b1; w_b_imm = 1'b1; w_wr = 1'b1; w_jump = 1'b1;
        w_rs1_used = 1'b1;
      end
      OPC_BRANCH: begin
        w_imm = w_imm_b; w_alu_op = ALU_SUB; w_branch = 1'b1;
        w_rs1_used = 1'b1; w_rs2_used = 1'b1;
      end
      OPC_LOAD: begin
        w_imm = w_imm_i; w_b_imm = 1'b1; w_mem_read = 1'b1; w_wr = 1'b1; w_m2r = 1'b1;
        w_rs1_used = 1'b1;
      end
      OPC_STORE: begin
        w_imm = w_imm_s; w_b_imm = 1'b1; w_mem_write = 1'b1;
        w_rs1_used = 1'b1; w_rs2_used = 1'b1;
      end
      OPC_OPIMM: begin
        w_imm = w_imm_i; w_alu_op = w_alu_arith; w_b_imm = 1'b1; w_wr = 1'b1;
        w_rs1_used = 1'b1;
      end
      OPC_OP:     begin w_alu_op = w_alu_arith; w_wr = 1'b1; w_rs1_used = 1'b1; w_rs2_used = 1'b1; end
      default:    w_illegal = (NOP_ON_ILLEGAL != 0);
    endcase
  end

  assign w_reg_write = w_wr && (w_rd != 5'd0);

  assign w_hazard = if_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                    ((w_rs1_used && ex_rd == rs1_addr) || (w_rs2_used && ex_rd == rs2_addr));
  assign stall_if = !rst && !ex_flush && w_hazard;
  assign w_bubble = ex_flush || w_hazard || !if_valid;

  // Bubbles clear only controls; data fields hold since ex_valid = 0 masks them downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rs1_val    <= '0;
      ex_rs2_val    <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_alu_op     <= '0;
      ex_alu_a_pc   <= 1'b0;
      ex_alu_b_imm  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_branch     <= 1'b0;
      ex_jump       <= 1'b0;
      ex_funct3     <= '0;
      ex_illegal    <= 1'b0;
    end else if (w_bubble) begin
      ex_valid      <= 1'b0;
      ex_alu_op     <= '0;
      ex_alu_a_pc   <= 1'b0;
      ex_alu_b_imm  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_branch     <= 1'b0;
      ex_jump       <= 1'b0;
      ex_funct3     <= '0;
      ex_illegal    <= 1'b0;
    end else begin
      ex_valid      <= 1'b1;
      ex_pc         <= if_pc;
      ex_rs1_val    <= rs1_data;
      ex_rs2_val    <= rs2_data;
      ex_imm        <= w_imm;
      ex_rs1        <= rs1_addr;
      ex_rs2        <= rs2_addr;
      ex_rd         <= w_rd;
      ex_alu_op     <= w_alu_op;
      ex_alu_a_pc   <= w_a_pc;
      ex_alu_b_imm  <= w_b_imm;
      ex_mem_read   <= w_mem_read;
      ex_mem_write  <= w_mem_write;
      ex_reg_write  <= w_reg_write;
      ex_mem_to_reg <= w_m2r;
      ex_branch     <= w_branch;
      ex_jump       <= w_jump;
      ex_funct3     <= w_funct3;
      ex_illegal    <= w_illegal;
    end
  end

`ifdef DECODE_STATS_EN
  logic [31:0] r_stat_stalls, r_stat_flushes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_stalls  <= '0;
      r_stat_flushes <= '0;
    end else begin
      if (stall_if) r_stat_stalls  <= r_stat_stalls + 32'd1;
      if (ex_flush) r_stat_flushes <= r_stat_flushes + 32'd1;
    end
  end

  assign stat_stalls  = r_stat_stalls;
  assign stat_flushes = r_stat_flushes;
`else
  assign stat_stalls  = '0;
  assign stat_flushes = '0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - table-driven, scoreboarded bench for decode_stage
`timescale 1ns/1ps
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, rs1_data, rs2_data;
  logic        ex_flush;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        stall_if, ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_a_pc, ex_alu_b_imm, ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_mem_to_reg, ex_branch, ex_jump, ex_illegal;
  logic [2:0]  ex_funct3;
  logic [31:0] stat_stalls, stat_flushes;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ex_flush(ex_flush), .stall_if(stall_if), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_alu_a_pc(ex_alu_a_pc),
    .ex_alu_b_imm(ex_alu_b_imm), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_funct3(ex_funct3), .ex_illegal(ex_illegal),
    .stat_stalls(stat_stalls), .stat_flushes(stat_flushes)
  );

  // ctrl = {alu_op, a_pc, b_imm, mem_read, mem_write, reg_write, mem_to_reg, branch, jump, illegal, funct3}
  logic [15:0]  act_ctrl;
  logic [142:0] act_data;
  assign act_ctrl = {ex_alu_op, ex_alu_a_pc, ex_alu_b_imm, ex_mem_read, ex_mem_write, ex_reg_write,
                     ex_mem_to_reg, ex_branch, ex_jump, ex_illegal, ex_funct3};
  assign act_data = {ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1, ex_rs2, ex_rd};

  typedef struct {
    logic         valid;
    logic [15:0]  ctrl;
    logic [142:0] data;
  } exp_t;

  // flags = {a_pc, b_imm, mem_read, mem_write, reg_write, mem_to_reg, branch, jump, illegal}
  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic [8:0]  flags;
    logic [2:0]  f3;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];
  vec_t v_add, v_lw7, v_sw7;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_vec(input vec_t v, input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    e.valid = 1'b1;
    e.ctrl  = {v.alu, v.flags, v.f3};
    e.data  = {pc, r1, r2, v.imm, v.rs1, v.rs2, v.rd};
    sb_q.push_back(e);
  endtask

  task automatic push_bubble();
    exp_t e;
    e.valid = 1'b0;
    e.ctrl  = '0;
    e.data  = '0;
    sb_q.push_back(e);
  endtask

  task automatic cycle(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input logic flush,
                       input logic exp_stall, input logic [4:0] ea1, input logic [4:0] ea2);
    exp_t e;
    @(negedge clk);
    if_valid = v; if_instr = instr; if_pc = pc; rs1_data = r1; rs2_data = r2; ex_flush = flush;
    #1;
    check("stall_if", stall_if, exp_stall);
    check("rs1_addr", rs1_addr, ea1);
    check("rs2_addr", rs2_addr, ea2);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: queue empty, got ex_valid %0b", ex_valid);
    end else begin
      e = sb_q.pop_front();
      check("ex_valid", ex_valid, e.valid);
      if (e.valid) begin
        check("ex_ctrl", act_ctrl, e.ctrl);
        check("ex_data", act_data, e.data);
      end else begin
        check("bubble_ctrl", act_ctrl[15:3], e.ctrl[15:3]);
      end
    end
  endtask

  task automatic check_stats(input string name, input logic [31:0] stalls, input logic [31:0] flushes);
`ifdef DECODE_STATS_EN
    check({name, "_stalls"}, stat_stalls, stalls);
    check({name, "_flushes"}, stat_flushes, flushes);
`else
    check({name, "_stalls"}, stat_stalls, 32'h0);
    check({name, "_flushes"}, stat_flushes, 32'h0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc, r1, r2;
    vecs[0]  = '{32'h00718293, 32'h00000007, 5'd3,  5'd7,  5'd5,  4'd0,  9'b010010000, 3'd0}; // addi x5,x3,7
    vecs[1]  = '{32'h40C58533, 32'h00000000, 5'd11, 5'd12, 5'd10, 4'd1,  9'b000010000, 3'd0}; // sub x10,x11,x12
    vecs[2]  = '{32'hFE412E23, 32'hFFFFFFFC, 5'd2,  5'd4,  5'd28, 4'd0,  9'b010100000, 3'd2}; // sw x4,-4(x2)
    vecs[3]  = '{32'h123450B7, 32'h12345000, 5'd8,  5'd3,  5'd1,  4'd10, 9'b010010000, 3'd5}; // lui x1,0x12345
    vecs[4]  = '{32'h00100013, 32'h00000001, 5'd0,  5'd1,  5'd0,  4'd0,  9'b010000000, 3'd0}; // addi x0,x0,1
    vecs[5]  = '{32'h0000007F, 32'h00000000, 5'd0,  5'd0,  5'd0,  4'd0,  9'b000000001, 3'd0}; // illegal
    vecs[6]  = '{32'h40335293, 32'h00000403, 5'd6,  5'd3,  5'd5,  4'd7,  9'b010010000, 3'd5}; // srai x5,x6,3
    vecs[7]  = '{32'hFE208CE3, 32'hFFFFFFF8, 5'd1,  5'd2,  5'd25, 4'd1,  9'b000000100, 3'd0}; // beq x1,x2,-8
    vecs[8]  = '{32'h010000EF, 32'h00000010, 5'd0,  5'd16, 5'd1,  4'd0,  9'b110010010, 3'd0}; // jal x1,16
    vecs[9]  = '{32'h00008067, 32'h00000000, 5'd1,  5'd0,  5'd0,  4'd0,  9'b110000010, 3'd0}; // jalr x0,0(x1)
    vecs[10] = '{32'hFFFFF197, 32'hFFFFF000, 5'd31, 5'd31, 5'd3,  4'd0,  9'b110010000, 3'd7}; // auipc x3,0xFFFFF
    vecs[11] = '{32'h00A4F433, 32'h00000000, 5'd9,  5'd10, 5'd8,  4'd9,  9'b000010000, 3'd7}; // and x8,x9,x10
    vecs[12] = '{32'h00012303, 32'h00000000, 5'd2,  5'd0,  5'd6,  4'd0,  9'b011011000, 3'd2}; // lw x6,0(x2)
    v_add    = '{32'h001303B3, 32'h00000000, 5'd6,  5'd1,  5'd7,  4'd0,  9'b000010000, 3'd0}; // add x7,x6,x1
    v_lw7    = '{32'h00032383, 32'h00000000, 5'd6,  5'd0,  5'd7,  4'd0,  9'b011011000, 3'd2}; // lw x7,0(x6)
    v_sw7    = '{32'h00712023, 32'h00000000, 5'd2,  5'd7,  5'd0,  4'd0,  9'b010100000, 3'd2}; // sw x7,0(x2)

    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; rs1_data = '0; rs2_data = '0; ex_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", ex_valid, 1'b0);
    check("reset_ctrl", act_ctrl, 16'h0);
    check("reset_data", act_data, 143'h0);
    check("reset_stall", stall_if, 1'b0);
    check("reset_stats", {stat_stalls, stat_flushes}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      pc = 32'h100 + 32'(i * 4);
      r1 = (i == 0) ? 32'd6 : $urandom;
      r2 = $urandom;
      push_vec(vecs[i], pc, r1, r2);
      cycle(1'b1, vecs[i].instr, pc, r1, r2, 1'b0, 1'b0, vecs[i].rs1, vecs[i].rs2);
    end
    push_bubble();
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);

    // load-use on rs1: one bubble, then the add captures fresh operands
    push_vec(vecs[12], 32'h200, 32'h1000, 32'h0);
    cycle(1'b1, vecs[12].instr, 32'h200, 32'h1000, 32'h0, 1'b0, 1'b0, 5'd2, 5'd0);
    push_bubble();
    cycle(1'b1, v_add.instr, 32'h204, 32'h11, 32'h22, 1'b0, 1'b1, 5'd6, 5'd1);
    push_vec(v_add, 32'h204, 32'h33, 32'h22);
    cycle(1'b1, v_add.instr, 32'h204, 32'h33, 32'h22, 1'b0, 1'b0, 5'd6, 5'd1);

    // back-to-back dependent loads, second dependency through rs2 of a store
    push_vec(vecs[12], 32'h208, 32'h1000, 32'h0);
    cycle(1'b1, vecs[12].instr, 32'h208, 32'h1000, 32'h0, 1'b0, 1'b0, 5'd2, 5'd0);
    push_bubble();
    cycle(1'b1, v_lw7.instr, 32'h20C, 32'h5, 32'h0, 1'b0, 1'b1, 5'd6, 5'd0);
    push_vec(v_lw7, 32'h20C, 32'h2000, 32'h0);
    cycle(1'b1, v_lw7.instr, 32'h20C, 32'h2000, 32'h0, 1'b0, 1'b0, 5'd6, 5'd0);
    push_bubble();
    cycle(1'b1, v_sw7.instr, 32'h210, 32'h1000, 32'h7, 1'b0, 1'b1, 5'd2, 5'd7);
    push_vec(v_sw7, 32'h210, 32'h1000, 32'h77);
    cycle(1'b1, v_sw7.instr, 32'h210, 32'h1000, 32'h77, 1'b0, 1'b0, 5'd2, 5'd7);
    check_stats("stats_after_stalls", 32'd3, 32'd0);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // hazard and flush together: flush wins, no stall
    push_vec(vecs[12], 32'h300, 32'h1000, 32'h0);
    cycle(1'b1, vecs[12].instr, 32'h300, 32'h1000, 32'h0, 1'b0, 1'b0, 5'd2, 5'd0);
    push_bubble();
    cycle(1'b1, v_add.instr, 32'h304, 32'h1, 32'h2, 1'b1, 1'b0, 5'd6, 5'd1);
    check_stats("stats_after_flush", 32'd0, 32'd1);

    // reset asserted in the middle of a stall cycle
    push_vec(vecs[12], 32'h400, 32'h1000, 32'h0);
    cycle(1'b1, vecs[12].instr, 32'h400, 32'h1000, 32'h0, 1'b0, 1'b0, 5'd2, 5'd0);
    @(negedge clk);
    if_valid = 1'b1; if_instr = v_add.instr; if_pc = 32'h404; rs1_data = 32'h9; rs2_data = 32'h8; ex_flush = 1'b0;
    #1;
    check("pre_reset_stall", stall_if, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_valid", ex_valid, 1'b0);
    check("async_reset_ctrl", act_ctrl, 16'h0);
    check("async_reset_data", act_data, 143'h0);
    check("async_reset_stall", stall_if, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    push_vec(vecs[0], 32'h500, 32'd6, 32'h0);
    cycle(1'b1, vecs[0].instr, 32'h500, 32'd6, 32'h0, 1'b0, 1'b0, 5'd3, 5'd7);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
